// File: rtl/rf_seq_pkg.sv
// Shared types for the register-file operation sequencer: op codes, FSM states
// and the 32-bit saturation limits used when RF_OP_SEQUENCER_SAT_EN is defined.
package rf_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [31:0] SAT_POS_32 = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG_32 = 32'h8000_0000;

    // Two's-complement overflow: the result sign disagrees with what the operand signs imply.
    function automatic logic add_sub_ovf(input logic a_msb, input logic b_msb,
                                         input logic r_msb, input logic is_sub);
        logic same_sign;
        same_sign = is_sub ? (a_msb != b_msb) : (a_msb == b_msb);
        return same_sign && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for rf_op_sequencer: ADD/SUB/AND/OR with signed overflow flag;
// clamps overflowing ADD/SUB results when RF_OP_SEQUENCER_SAT_EN is defined.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    always_comb begin
        sum    = a + b;
        diff   = a - b;
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum;
                ovf    = add_sub_ovf(a[DATA_W-1], b[DATA_W-1], sum[DATA_W-1], 1'b0);
            end
            OP_SUB: begin
                result = diff;
                ovf    = add_sub_ovf(a[DATA_W-1], b[DATA_W-1], diff[DATA_W-1], 1'b1);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            default: result = '0;
        endcase
`ifdef RF_OP_SEQUENCER_SAT_EN
        // On overflow the true result always has the sign of operand a.
        if (ovf) begin
            result = a[DATA_W-1] ? SAT_NEG : SAT_POS;
        end
`endif
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// Sequences one ALU command through regfile read, execute, write and a done handshake.
// Optional build macro: RF_OP_SEQUENCER_SAT_EN (saturating ADD/SUB results).
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              rf_w_en,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wd,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [DATA_W-1:0] done_result,
    output logic              done_ovf
);

    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] result_q;
    logic              ovf_q;

    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;

    rf_seq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_q),
        .a      (opa_q),
        .b      (opb_q),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    // cmd_ready is registered, so it rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= OP_ADD;
            rd_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            cmd_ready   <= 1'b0;
            rf_rs1      <= '0;
            rf_rs2      <= '0;
            rf_w_en     <= 1'b0;
            rf_rd       <= '0;
            rf_wd       <= '0;
            done_valid  <= 1'b0;
            done_result <= '0;
            done_ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= op_e'(cmd_op);
                        rf_rs1    <= cmd_rs1;
                        rf_rs2    <= cmd_rs2;
                        rd_q      <= cmd_rd;
                        cmd_ready <= 1'b0;
                        state     <= ST_READ;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_READ: begin
                    opa_q <= rf_rd1;
                    opb_q <= rf_rd2;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    ovf_q    <= alu_ovf;
                    rf_rd    <= rd_q;
                    rf_wd    <= alu_result;
                    // x0 is read-only: the result is still reported, just never written.
                    rf_w_en  <= (rd_q != '0);
                    state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    rf_w_en     <= 1'b0;
                    done_valid  <= 1'b1;
                    done_result <= result_q;
                    done_ovf    <= ovf_q;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        cmd_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    rf_w_en    <= 1'b0;
                    done_valid <= 1'b0;
                    cmd_ready  <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Scoreboard bench for rf_op_sequencer: directed commands against a behavioural regfile.
module tb_rf_op_sequencer;
    import rf_seq_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

`ifdef RF_OP_SEQUENCER_SAT_EN
    localparam logic [31:0] E_ADD_OVF  = 32'h7FFF_FFFF;
    localparam logic [31:0] E_ADD_NEG2 = 32'h8000_0000;
    localparam logic [31:0] E_SUB_OVF  = 32'h8000_0000;
`else
    localparam logic [31:0] E_ADD_OVF  = 32'h8000_0000;
    localparam logic [31:0] E_ADD_NEG2 = 32'h0000_0000;
    localparam logic [31:0] E_SUB_OVF  = 32'h7FFF_FFFF;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
    logic [AW-1:0] rf_rs1, rf_rs2, rf_rd;
    logic [DW-1:0] rf_rd1, rf_rd2, rf_wd;
    logic          rf_w_en;
    logic          done_valid;
    logic          done_ready = 1'b1;
    logic [DW-1:0] done_result;
    logic          done_ovf;

    rf_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_w_en(rf_w_en), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_result(done_result), .done_ovf(done_ovf)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] regs [32];
    assign rf_rd1 = regs[rf_rs1];
    assign rf_rd2 = regs[rf_rs2];
    always @(posedge clk) if (rf_w_en && rf_rd != '0) regs[rf_rd] <= rf_wd;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] res; logic ovf; int at_edge; } done_t;
    typedef struct { logic [4:0] rd; logic [31:0] wd; int at_edge; } wr_t;
    done_t done_q[$];
    wr_t   wr_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_reg(input int idx, input logic [31:0] v);
        regs[idx] <= v;
    endtask

    // Monitor: every write and every completed handshake is popped against the scoreboard.
    logic prev_dv = 1'b0;
    always @(negedge clk) begin
        wr_t   w;
        done_t d;
        if (!rst_n) begin
            prev_dv <= 1'b0;
        end else begin
            if (rf_w_en) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: got rd=%0d wd=%h expected no write", rf_rd, rf_wd);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_rd", 32'(rf_rd), 32'(w.rd));
                    chk("wr_data", rf_wd, w.wd);
                    chk("wr_edge", 32'(cyc + 1), 32'(w.at_edge));
                end
            end
            if (done_valid && !prev_dv) begin
                if (done_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_done: got result=%h expected no done", done_result);
                end else begin
                    chk("done_edge", 32'(cyc), 32'(done_q[0].at_edge));
                end
            end
            if (done_valid && done_ready && done_q.size() > 0) begin
                d = done_q.pop_front();
                chk("done_result", done_result, d.res);
                chk("done_ovf", 32'(done_ovf), 32'(d.ovf));
            end
            prev_dv <= done_valid;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] res, input logic ovf,
                         input bit expect_it, output int k);
        bit acc;
        acc = 1'b0;
        k = -1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = 1'b1;
                k = cyc + 1;
                break;
            end
        end
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 50 cycles");
        end else if (expect_it) begin
            done_q.push_back('{res, ovf, k + 3});
            if (rd != 5'd0) wr_q.push_back('{rd, res, k + 3});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: got cmd_ready=0 expected 1 within 60 cycles");
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] res, input logic ovf);
        int k;
        issue(op, rs1, rs2, rd, res, ovf, 1'b1, k);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < 32; i++) regs[i] <= '0;

        // Reset values while rst_n is low.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_w_en", 32'(rf_w_en), 0);
        chk("rst_done_valid", 32'(done_valid), 0);
        chk("rst_done_ovf", 32'(done_ovf), 0);
        chk("rst_addrs", 32'({rf_rs1, rf_rs2, rf_rd}), 0);
        chk("rst_data", rf_wd | done_result, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rel_cmd_ready", 32'(cmd_ready), 1);

        set_reg(1, 32'd10); set_reg(2, 32'd20);
        run(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd30, 1'b0);
        chk("x3_add", regs[3], 32'd30);

        set_reg(2, 32'd5);
        run(OP_SUB, 5'd1, 5'd2, 5'd3, 32'd5, 1'b0);
        chk("x3_sub", regs[3], 32'd5);
        run(OP_SUB, 5'd2, 5'd1, 5'd4, 32'hFFFF_FFFB, 1'b0);
        chk("x4_sub", regs[4], 32'hFFFF_FFFB);

        set_reg(1, 32'h7FFF_FFFF); set_reg(2, 32'd1);
        run(OP_ADD, 5'd1, 5'd2, 5'd5, E_ADD_OVF, 1'b1);
        chk("x5_ovf", regs[5], E_ADD_OVF);

        set_reg(1, 32'd10); set_reg(2, 32'd20);
        run(OP_ADD, 5'd1, 5'd2, 5'd0, 32'd30, 1'b0);
        chk("x0_ro", regs[0], 32'd0);

        set_reg(1, 32'hF0F0_1234); set_reg(2, 32'h0FF0_00FF);
        run(OP_AND, 5'd1, 5'd2, 5'd7, 32'h00F0_0034, 1'b0);
        run(OP_OR,  5'd1, 5'd2, 5'd8, 32'hFFF0_12FF, 1'b0);
        chk("x8_or", regs[8], 32'hFFF0_12FF);

        // Same-register sources and destination: operands are read before the write.
        set_reg(9, 32'h8000_0000);
        run(OP_ADD, 5'd9, 5'd9, 5'd9, E_ADD_NEG2, 1'b1);
        chk("x9_self", regs[9], E_ADD_NEG2);
        set_reg(10, 32'h8000_0000); set_reg(11, 32'd1);
        run(OP_SUB, 5'd10, 5'd11, 5'd12, E_SUB_OVF, 1'b1);
        run(OP_SUB, 5'd12, 5'd12, 5'd12, 32'd0, 1'b0);
        chk("x12_self", regs[12], 32'd0);

        // Back-pressure on the done port with a second command waiting.
        set_reg(1, 32'd10); set_reg(2, 32'd20);
        done_ready = 1'b0;
        issue(OP_ADD, 5'd1, 5'd2, 5'd13, 32'd30, 1'b0, 1'b1, k);
        for (int i = 0; i < 10 && !done_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_op = OP_AND; cmd_rs1 = 5'd2; cmd_rs2 = 5'd1; cmd_rd = 5'd14;
            @(negedge clk);
            chk("stall_valid", 32'(done_valid), 1);
            chk("stall_result", done_result, 32'd30);
            chk("stall_cmd_ready", 32'(cmd_ready), 0);
            chk("stall_rs1", 32'(rf_rs1), 1);
        end
        @(posedge clk); #1 done_ready = 1'b1;
        run(OP_AND, 5'd2, 5'd1, 5'd14, 32'd0, 1'b0);
        chk("x13_stall", regs[13], 32'd30);

        // Reset asserted during EXEC aborts the command with no write.
        set_reg(6, 32'h55);
        issue(OP_ADD, 5'd1, 5'd2, 5'd6, 32'd30, 1'b0, 1'b0, k);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_w_en", 32'(rf_w_en), 0);
        chk("abort_cmd_ready", 32'(cmd_ready), 0);
        chk("abort_done_valid", 32'(done_valid), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_rel_ready", 32'(cmd_ready), 1);
        repeat (5) @(negedge clk);
        chk("abort_x6", regs[6], 32'h55);

        repeat (3) @(negedge clk);
        chk("sb_done_empty", 32'(done_q.size()), 0);
        chk("sb_wr_empty", 32'(wr_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_op_sequencer.md
RF_OP_SEQUENCER -- requirements
Module: rf_op_sequencer

Interface
REQ-001 Parameter DATA_W, 32, register/data width.
REQ-002 Parameter ADDR_W, 5, register index width (32 registers).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_op  input  2  operation: ADD=0, SUB=1, AND=2, OR=3.
REQ-008 cmd_rs1, cmd_rs2, cmd_rd  input  ADDR_W each  source and destination indices.
REQ-009 rf_rs1, rf_rs2  output  ADDR_W each  regfile read addresses.
REQ-010 rf_rd1, rf_rd2  input  DATA_W each  regfile read data (combinational from rf_rs1/rf_rs2).
REQ-011 rf_w_en  output  1  regfile write enable.
REQ-012 rf_rd  output  ADDR_W  regfile write address.
REQ-013 rf_wd  output  DATA_W  regfile write data.
REQ-014 done_valid  output  1  result available.
REQ-015 done_ready  input  1  result consumed.
REQ-016 done_result  output  DATA_W  value written (or suppressed, see REQ-024).
REQ-017 done_ovf  output  1  signed overflow of ADD/SUB; 0 for AND/OR.

Function
REQ-018 FSM states IDLE, READ, EXEC, WRITE, DONE; one state per cycle except IDLE and DONE.
REQ-019 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch op/rs1/rs2/rd, go READ; cmd_ready=0 in all other states.
REQ-020 READ: rf_rs1/rf_rs2 driven from latched indices (registered, stable whole cycle); rf_rd1/rf_rd2 captured into operand registers at cycle end; go EXEC.
REQ-021 EXEC: result and overflow computed from captured operands and registered; go WRITE.
REQ-022 WRITE: rf_w_en=1, rf_rd=latched rd, rf_wd=result for exactly one cycle; go DONE.
REQ-023 DONE: done_valid=1, done_result/done_ovf held stable until done_valid&&done_ready, then IDLE (cmd_ready high next cycle).
REQ-024 cmd_rd==0: rf_w_en stays 0 in WRITE (x0 read-only); done_result still reports computed value.
REQ-025 Latency: command accepted at edge k -> regfile write at edge k+3 -> done_valid high after edge k+3.
REQ-026 Arithmetic mod 2^DATA_W; SUB = rs1 - rs2; overflow = signed-operand sign rule.
REQ-027 rs1==rs2, or rd equal to a source: operands read before write; no forwarding needed.
REQ-028 rf_w_en, done_valid never high outside WRITE/DONE respectively; rf_rs1/rf_rs2/rf_rd/rf_wd hold last value otherwise.

Reset
REQ-029 rst_n low asynchronously forces IDLE, rf_w_en=0, done_valid=0, cmd_ready=0 while low, done_ovf=0, all address/data outputs 0.
REQ-030 Reset mid-operation (any state) aborts the command; no regfile write issued after rst_n asserts; cmd_ready=1 first cycle after release.

Configuration
REQ-031 Macro RF_OP_SEQUENCER_SAT_EN: when defined, ADD/SUB results that overflow clamp to 0x7FFFFFFF (positive) or 0x80000000 (negative) and done_ovf=1; when undefined, results wrap and done_ovf still reports overflow.

Structure
REQ-032 Shared package rf_seq_pkg: op enum (ADD/SUB/AND/OR), FSM state enum, saturation constants.
REQ-033 One sub-module rf_seq_alu: combinational op/operands -> result, ovf (saturation inside under macro).

Verification
REQ-034 Regfile model x1=10, x2=20; cmd ADD rs1=1 rs2=2 rd=3 -> rf_w_en one cycle at edge k+3, x3=30, done_result=30, done_ovf=0.
REQ-035 x1=10, x2=5; cmd SUB rs1=1 rs2=2 rd=3 -> x3=5; then cmd SUB rs1=2 rs2=1 rd=4 -> x4=0xFFFFFFFB, done_ovf=0.
REQ-036 x1=0x7FFFFFFF, x2=1; ADD rd=5 -> with SAT_EN x5=0x7FFFFFFF, done_ovf=1; without x5=0x80000000, done_ovf=1.
REQ-037 ADD rd=0 with x1=10, x2=20 -> rf_w_en never asserted, done_result=30.
REQ-038 done_ready held low 5 cycles -> done_valid/done_result stable, cmd_ready=0, second cmd_valid not accepted until handshake.
REQ-039 rst_n pulsed low during EXEC -> no rf_w_en pulse, target register unchanged, cmd_ready=1 after release.
